// File: rtl/press_timer_if.sv
// press_timer_if: button and game-state inputs plus jump
// timing/direction outputs between the input stage and VGA_Display.
interface press_timer_if;
   logic       btn;
   logic       end_game;
   logic       score_signal;
   logic       is_pressing;
   logic [3:0] press_time;
   logic       launch;
   logic [1:0] position;

   modport master (
      output btn, end_game, score_signal,
      input  is_pressing, press_time, launch, position
   );

   modport slave (
      input  btn, end_game, score_signal,
      output is_pressing, press_time, launch, position
   );
endinterface

// File: rtl/press_timer.sv
// press_timer: debounced jump-button hold timer and
// pseudo-random plate direction picker feeding VGA_Display.
module press_timer #(
   parameter int unsigned DEB_CYCLES  = 500000,
   parameter int unsigned TICK_CYCLES = 6250000,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input logic          clk,
   input logic          rst,
   press_timer_if.slave bus
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REL
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic          r_btn_s1;
   logic          r_btn_s2;
   logic          r_deb;
   logic [DW-1:0] r_deb_cnt;
   logic          r_sc_s1;
   logic          r_sc_s2;
   logic          r_sc_q;
   logic [7:0]    r_lfsr;
   logic [1:0]    r_pos;
   logic [TW-1:0] r_tick;
   logic [TW-1:0] w_tick_nx;
   logic [3:0]    r_ptime;
   logic [3:0]    w_ptime_nx;
   logic          r_press;
   logic          w_press_nx;
   logic          w_mis;
   logic          w_flip;
   logic          w_rise;
   logic          w_fall;
   logic          w_sc_edge;
   logic          w_fb;

   assign w_mis     = r_btn_s2 ^ r_deb;
   assign w_flip    = w_mis && (r_deb_cnt == DEB_LAST);
   assign w_rise    = w_flip && !r_deb;
   assign w_fall    = w_flip && r_deb;
   assign w_sc_edge = r_sc_s2 ^ r_sc_q;
   assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_s1 <= 1'b0;
         r_btn_s2 <= 1'b0;
         r_sc_s1  <= 1'b0;
         r_sc_s2  <= 1'b0;
         r_sc_q   <= 1'b0;
      end else begin
         r_btn_s1 <= bus.btn;
         r_btn_s2 <= r_btn_s1;
         r_sc_s1  <= bus.score_signal;
         r_sc_s2  <= r_sc_s1;
         r_sc_q   <= r_sc_s2;
      end
   end

   // a level change is accepted only after DEB_CYCLES stable samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_deb     <= 1'b0;
         r_deb_cnt <= '0;
      end else if (!w_mis) begin
         r_deb_cnt <= '0;
      end else if (w_flip) begin
         r_deb     <= ~r_deb;
         r_deb_cnt <= '0;
      end else begin
         r_deb_cnt <= r_deb_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr <= LFSR_SEED;
         r_pos  <= 2'b11;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         if (w_sc_edge) begin
            r_pos <= r_lfsr[1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_tick  <= '0;
         r_ptime <= 4'd0;
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_tick  <= w_tick_nx;
         r_ptime <= w_ptime_nx;
         r_press <= w_press_nx;
      end
   end

   // end_game overrides everything and cancels a pending launch
   always_comb begin
      w_state_nx = r_state;
      w_tick_nx  = r_tick;
      w_ptime_nx = r_ptime;
      w_press_nx = r_press;
      if (bus.end_game) begin
         w_state_nx = S_IDLE;
         w_press_nx = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  w_state_nx = S_HOLD;
                  w_ptime_nx = 4'd1;
                  w_tick_nx  = '0;
                  w_press_nx = 1'b1;
               end
            end
            S_HOLD: begin
               if (w_fall) begin
                  w_state_nx = S_REL;
                  w_press_nx = 1'b0;
               end else if (r_tick == TICK_LAST) begin
                  w_tick_nx = '0;
                  if (r_ptime != 4'd15) begin
                     w_ptime_nx = r_ptime + 4'd1;
                  end
               end else begin
                  w_tick_nx = r_tick + 1'b1;
               end
            end
            S_REL: begin
               w_state_nx = S_IDLE;
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   assign bus.is_pressing = r_press;
   assign bus.press_time  = r_ptime;
   assign bus.launch      = (r_state == S_REL);
   assign bus.position    = r_pos;

endmodule

// File: tb/tb_press_timer.sv
// tb_press_timer: directed stimulus with queued expectations for
// launch press_time and position updates, checked by a monitor.
module tb_press_timer;

   logic clk;
   logic rst;

   press_timer_if u_if ();

   press_timer #(
      .DEB_CYCLES (4),
      .TICK_CYCLES(8),
      .LFSR_SEED  (8'hA5)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if)
   );

   typedef struct packed {
      int unsigned due;
      logic [1:0]  val;
   } pos_ev_t;

   int unsigned n_err;
   int unsigned n_chk;
   int unsigned cyc;
   int unsigned pos_bad;
   logic [3:0]  q_launch[$];
   pos_ev_t     q_pos[$];
   logic [1:0]  exp_pos;
   logic [7:0]  m_lfsr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 8'hA5;
      else      m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // monitor: pops queued expectations when the DUT presents them
   always @(negedge clk) begin
      logic [3:0] exp_l;
      pos_ev_t    ev;
      if (!rst) begin
         exp_pos = 2'b11;
      end else begin
         if (u_if.launch === 1'b1) begin
            if (q_launch.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL launch_unexpected: press_time=%0d want none",
                        u_if.press_time);
            end else begin
               exp_l = q_launch.pop_front();
               chk("launch_ptime", {28'd0, u_if.press_time}, {28'd0, exp_l});
            end
         end
         if (q_pos.size() != 0 && q_pos[0].due == cyc) begin
            ev      = q_pos.pop_front();
            exp_pos = ev.val;
            chk("position", {30'd0, u_if.position}, {30'd0, exp_pos});
         end else if (u_if.position !== exp_pos) begin
            pos_bad++;
            $display("FAIL pos_unexpected: got %0d want %0d",
                     u_if.position, exp_pos);
            exp_pos = u_if.position;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_press(input string nm);
      int k;
      k = 0;
      while (u_if.is_pressing !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {31'd0, u_if.is_pressing}, 32'd1);
   endtask

   task automatic press_release(input int hold, input logic [3:0] exp);
      @(negedge clk);
      u_if.btn = 1'b1;
      wait_press("press_rise");
      tick(hold);
      u_if.btn = 1'b0;
      q_launch.push_back(exp);
      tick(12);
      chk("ptime_idle", {28'd0, u_if.press_time}, {28'd0, exp});
      chk("is_pressing_idle", {31'd0, u_if.is_pressing}, 32'd0);
      chk("launch_seen", q_launch.size(), 32'd0);
      tick(10);
      chk("ptime_held", {28'd0, u_if.press_time}, {28'd0, exp});
   endtask

   task automatic toggle_score();
      pos_ev_t ev;
      logic [7:0] v;
      u_if.score_signal = ~u_if.score_signal;
      v = lfsr_step(lfsr_step(m_lfsr));
      ev.due = cyc + 3;
      ev.val = v[1:0];
      q_pos.push_back(ev);
   endtask

   initial begin
      int seen;
      n_err   = 0;
      n_chk   = 0;
      cyc     = 0;
      pos_bad = 0;
      exp_pos = 2'b11;
      rst     = 1'b0;
      u_if.btn          = 1'b0;
      u_if.end_game     = 1'b0;
      u_if.score_signal = 1'b0;
      tick(2);
      chk("rst_is_pressing", {31'd0, u_if.is_pressing}, 32'd0);
      chk("rst_press_time", {28'd0, u_if.press_time}, 32'd0);
      chk("rst_launch", {31'd0, u_if.launch}, 32'd0);
      chk("rst_position", {30'd0, u_if.position}, 32'd3);
      rst = 1'b1;
      tick(3);

      // short glitch is rejected
      u_if.btn = 1'b1;
      tick(3);
      u_if.btn = 1'b0;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (u_if.is_pressing !== 1'b0) seen++;
      end
      chk("glitch_no_press", seen, 32'd0);
      chk("glitch_ptime", {28'd0, u_if.press_time}, 32'd0);

      // 40-clock hold: 46 cycles in HOLD -> 6
      press_release(40, 4'd6);

      // long hold saturates at 15
      @(negedge clk);
      u_if.btn = 1'b1;
      wait_press("long_rise");
      tick(150);
      chk("sat_ptime_150", {28'd0, u_if.press_time}, 32'd15);
      tick(50);
      chk("sat_ptime_200", {28'd0, u_if.press_time}, 32'd15);
      u_if.btn = 1'b0;
      q_launch.push_back(4'd15);
      tick(20);

      // end_game mid-hold, button kept down through clear
      u_if.btn = 1'b1;
      wait_press("eg_rise");
      tick(10);
      u_if.end_game = 1'b1;
      tick(1);
      chk("eg_is_pressing", {31'd0, u_if.is_pressing}, 32'd0);
      chk("eg_ptime", {28'd0, u_if.press_time}, 32'd2);
      tick(20);
      u_if.end_game = 1'b0;
      tick(20);
      chk("eg_held_no_press", {31'd0, u_if.is_pressing}, 32'd0);
      chk("eg_ptime_kept", {28'd0, u_if.press_time}, 32'd2);
      u_if.btn = 1'b0;
      tick(12);
      chk("eg_rel_no_press", {31'd0, u_if.is_pressing}, 32'd0);
      press_release(40, 4'd6);

      // end_game, then release while frozen: no launch
      @(negedge clk);
      u_if.btn = 1'b1;
      wait_press("eg2_rise");
      tick(5);
      u_if.end_game = 1'b1;
      tick(3);
      u_if.btn = 1'b0;
      tick(15);
      u_if.end_game = 1'b0;
      tick(10);
      chk("eg2_no_press", {31'd0, u_if.is_pressing}, 32'd0);

      // two score toggles -> two position updates
      toggle_score();
      tick(15);
      toggle_score();
      tick(15);
      chk("pos_updates_done", q_pos.size(), 32'd0);
      tick(10);

      // asynchronous reset mid-hold
      u_if.btn = 1'b1;
      wait_press("rst_rise");
      tick(5);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_is_pressing", {31'd0, u_if.is_pressing}, 32'd0);
      chk("arst_ptime", {28'd0, u_if.press_time}, 32'd0);
      chk("arst_position", {30'd0, u_if.position}, 32'd3);
      chk("arst_launch", {31'd0, u_if.launch}, 32'd0);
      u_if.btn = 1'b0;
      tick(3);
      #3 rst = 1'b1;
      tick(10);
      chk("post_rst_idle", {31'd0, u_if.is_pressing}, 32'd0);
      press_release(40, 4'd6);

      tick(5);
      chk("pos_stable", pos_bad, 32'd0);
      chk("launch_q_empty", q_launch.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
